// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides:
// FSM state encoding, parity type codes, prescale floor and frame bit counts.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Bit periods shorter than this cannot be resolved by the receiver.
   localparam logic [4:0] PRESCALE_MIN = 5'd2;

   localparam int START_BITS  = 1;
   localparam int PARITY_BITS = 1;
   localparam int STOP_BITS   = 1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator shared by the UART transmitter and the receive checker.
// Even parity is the XOR of the data bits; odd parity is its inverse.
module uart_parity_calc
   import uart_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   input  logic             par_typ,
   output logic             par_bit
);

   // XOR reduction, inverted for odd parity.
   always_comb begin
      par_bit = (^data) ^ (par_typ == PAR_ODD);
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit. Each bit lasts the latched prescale value
// in cycles (0 and 1 are clamped to 2).
// Parity support is built only when UART_TX_PARITY_EN is defined.
//
// Handshake: a request is taken in any cycle with DATA_VALID=1 and busy=0;
// requests while busy are dropped, there is no buffering. All frame inputs
// are latched on acceptance. TX_OUT and busy are registered, so both change
// one cycle after the accepting edge.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [4:0]            prescale,
   output logic                  TX_OUT,
   output logic                  busy,
   output uart_tx_state_t        tx_state
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   uart_tx_state_t        state_q, state_d;
   logic [4:0]            presc_q;
   logic [4:0]            cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  busy_q;
   logic                  accept;
   logic                  bit_end;
   logic                  par_active;
   logic                  par_bit;

   assign accept  = (state_q == ST_IDLE) && DATA_VALID;
   assign bit_end = (cnt_q == (presc_q - 5'd1));

`ifdef UART_TX_PARITY_EN
   logic                  par_en_q;
   logic                  par_typ_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Parity settings and an untouched copy of the byte, held for the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
         data_q    <= '0;
      end else if (accept) begin
         par_en_q  <= PAR_EN;
         par_typ_q <= PAR_TYP;
         data_q    <= P_DATA;
      end
   end

   uart_parity_calc #(.WIDTH(DATA_WIDTH)) u_parity (
      .data    (data_q),
      .par_typ (par_typ_q),
      .par_bit (par_bit)
   );

   assign par_active = par_en_q;
`else
   logic unused_par;
   assign unused_par = PAR_EN ^ PAR_TYP;
   assign par_active = 1'b0;
   assign par_bit    = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: every transition out of a frame state waits for the
   // end of the current bit period.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (DATA_VALID) state_d = ST_START;
         ST_START:  if (bit_end) state_d = ST_DATA;
         ST_DATA:   if (bit_end && (idx_q == LAST_IDX))
                       state_d = par_active ? ST_PARITY : ST_STOP;
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
         ST_STOP:   if (bit_end) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Shift register: load on accept, shift right after each data bit.
   always_comb begin
      shift_d = shift_q;
      if (accept)                            shift_d = P_DATA;
      else if ((state_q == ST_DATA) && bit_end) shift_d = shift_q >> 1;
   end

   // Output logic: line level for the upcoming cycle, from the next state.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_bit;
         default:   tx_d = 1'b1;
      endcase
   end

   // Bit-period counter, data bit index, prescale latch and shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= PRESCALE_MIN;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
         if (accept) begin
            presc_q <= (prescale < PRESCALE_MIN) ? PRESCALE_MIN : prescale;
            cnt_q   <= '0;
            idx_q   <= '0;
         end else if (state_q != ST_IDLE) begin
            cnt_q <= bit_end ? 5'd0 : (cnt_q + 5'd1);
            if ((state_q == ST_DATA) && bit_end)
               idx_q <= (idx_q == LAST_IDX) ? '0 : (idx_q + 1'b1);
         end
      end
   end

   // Registered outputs so the line never glitches between bit boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= (state_d != ST_IDLE);
      end
   end

   assign TX_OUT   = tx_q;
   assign busy     = busy_q;
   assign tx_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A driver pushes each accepted request
// onto exp_q; a negedge monitor detects the start bit, pops the entry and
// checks every cycle of the frame against a bit model built from it.
module tb_uart_tx;
   import uart_pkg::*;

   logic           clk = 1'b0;
   logic           rst;
   logic [7:0]     P_DATA;
   logic           DATA_VALID;
   logic           PAR_EN;
   logic           PAR_TYP;
   logic [4:0]     prescale;
   logic           TX_OUT;
   logic           busy;
   uart_tx_state_t tx_state;

   uart_tx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .prescale   (prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy),
      .tx_state   (tx_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   // entry = {par_typ, par_en, prescale[4:0], data[7:0]}
   logic [14:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   logic mon_active = 1'b0;
   logic mon_bits[0:10];
   int   mon_nbits, mon_bit, mon_cyc, mon_presc;
   int   frames_done = 0;
   int   gap = 0, gap_last = 0;
   int   busy_run = 0, last_busy_len = 0;

   always @(negedge clk) begin
      logic [14:0] e;
      logic [7:0]  d;
      logic        pe;
      if (rst) begin
         mon_active = 1'b0;
         busy_run   = 0;
      end else begin
         if (busy) busy_run++;
         else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
         end
         if (!mon_active) begin
            if (TX_OUT == 1'b0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", exp_q.size(), 1);
                  e = '0;
               end else begin
                  e = exp_q.pop_front();
               end
               d = e[7:0];
               mon_presc = (e[12:8] < 5'd2) ? 2 : int'(e[12:8]);
`ifdef UART_TX_PARITY_EN
               pe = e[13];
`else
               pe = 1'b0;
`endif
               mon_bits[0] = 1'b0;
               for (int i = 0; i < 8; i++) mon_bits[1+i] = d[i];
               if (pe) begin
                  mon_bits[9]  = (^d) ^ e[14];
                  mon_bits[10] = 1'b1;
                  mon_nbits    = 11;
               end else begin
                  mon_bits[9] = 1'b1;
                  mon_nbits   = 10;
               end
               mon_active = 1'b1;
               mon_bit = 0;
               mon_cyc = 0;
               gap_last = gap;
               gap = 0;
            end else begin
               gap++;
               check("idle_busy", busy, 0);
            end
         end
         if (mon_active) begin
            check("tx_bit", TX_OUT, mon_bits[mon_bit]);
            check("busy_hi", busy, 1);
            mon_cyc++;
            if (mon_cyc == mon_presc) begin
               mon_cyc = 0;
               mon_bit++;
               if (mon_bit == mon_nbits) begin
                  mon_active = 1'b0;
                  frames_done++;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic scramble_inputs();
      P_DATA   = 8'($urandom);
      prescale = 5'($urandom);
      PAR_EN   = 1'($urandom);
      PAR_TYP  = 1'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("wait_idle", busy, 0);
   endtask

   task automatic wait_frames(input int n);
      for (int i = 0; i < 20000; i++) begin
         if (frames_done >= n && !mon_active) break;
         @(negedge clk);
      end
      check("frames_done", frames_done >= n, 1);
   endtask

   // Returns at the negedge of the first START cycle.
   task automatic send(input logic [7:0] d, input logic [4:0] p, input logic pe, input logic pt);
      wait_idle();
      P_DATA = d; prescale = p; PAR_EN = pe; PAR_TYP = pt;
      DATA_VALID = 1'b1;
      exp_q.push_back({pt, pe, p, d});
      @(negedge clk);
      DATA_VALID = 1'b0;
      scramble_inputs();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nf;
      rst = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 5'd8;
      repeat (3) @(negedge clk);
      check("rst_tx", TX_OUT, 1);
      check("rst_busy", busy, 0);
      check("rst_state", tx_state, ST_IDLE);
      rst = 1'b0;
      nf = 0;

      // Basic frame, no parity: 80-cycle busy, registered start latency.
      send(8'hC5, 5'd8, 1'b0, 1'b0);
      check("start_tx", TX_OUT, 0);
      check("start_busy", busy, 1);
      nf++; wait_frames(nf);
      wait_idle();
      check("busy_len_80", last_busy_len, 80);

`ifdef UART_TX_PARITY_EN
      send(8'hC5, 5'd8, 1'b1, PAR_EVEN);
      nf++; wait_frames(nf); wait_idle();
      check("busy_len_88", last_busy_len, 88);
      send(8'hC5, 5'd8, 1'b1, PAR_ODD);
      nf++; wait_frames(nf); wait_idle();
      check("busy_len_88_odd", last_busy_len, 88);
`endif

      // Drop while busy: DATA_VALID held, data changes mid-frame.
      wait_idle();
      P_DATA = 8'hC5; prescale = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 5'd8, 8'hC5});
      repeat (20) @(negedge clk);
      P_DATA = 8'h3A;
      prescale = 5'd3;
      wait_idle();
      exp_q.push_back({1'b0, 1'b0, 5'd3, 8'h3A});
      @(negedge clk);
      DATA_VALID = 1'b0;
      scramble_inputs();
      nf += 2; wait_frames(nf);
      check("b2b_gap", gap_last, 1);

      // Reset mid-frame during data bit 3 (prescale 4 -> cycles 16..19).
      send(8'hA5, 5'd4, 1'b0, 1'b0);
      repeat (17) @(negedge clk);
      check("mid_state", tx_state, ST_DATA);
      check("mid_bit3", TX_OUT, 0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_tx", TX_OUT, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_state", tx_state, ST_IDLE);
      @(negedge clk);
      rst = 1'b0;
      send(8'hFF, 5'd8, 1'b0, 1'b0);
      nf++; wait_frames(nf);

      // Prescale clamp and maximum (inputs are scrambled mid-frame by send).
      send(8'h5A, 5'd0, 1'b0, 1'b0);
      nf++; wait_frames(nf); wait_idle();
      check("busy_len_p0", last_busy_len, 20);
      send(8'h96, 5'd1, 1'b0, 1'b0);
      nf++; wait_frames(nf); wait_idle();
      check("busy_len_p1", last_busy_len, 20);
      send(8'h69, 5'd31, 1'b0, 1'b0);
      nf++; wait_frames(nf); wait_idle();
      check("busy_len_p31", last_busy_len, 310);

      // Random frames.
      for (int i = 0; i < 40; i++) begin
         send(8'($urandom), 5'($urandom_range(0, 12)), 1'($urandom), 1'($urandom));
         nf++;
      end
      wait_frames(nf);
      wait_idle();
      check("queue_empty", exp_q.size(), 0);
      check("frame_count", frames_done, nf);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer: the transmit counterpart of the UART_RX deserializer. It accepts one parallel byte per handshake and drives a framed serial line: start bit, 8 data bits LSB first, optional parity bit, stop bit. Each bit is held for `prescale` clock cycles, so TX and RX share one clock and one prescale setting.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `P_DATA`  in  DATA_WIDTH  parallel byte to send.
- `DATA_VALID`  in  1  request to send `P_DATA`.
- `PAR_EN`  in  1  add a parity bit to this frame. Ignored when parity is compiled out.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity. Ignored when parity is compiled out.
- `prescale`  in  5  clock cycles per bit.
- `TX_OUT`  out  1  serial line; idles high.
- `busy`  out  1  frame in progress; new requests are ignored while high.

## Operation
- **Acceptance.** A request is accepted in any cycle where `DATA_VALID`=1 and `busy`=0.
  - `P_DATA`, `PAR_EN`, `PAR_TYP` and `prescale` are latched in that cycle.
  - Later changes to these inputs do not affect the frame in flight.
- **Requests while busy.** `DATA_VALID` while `busy`=1 is dropped. There is no buffering.
- **Prescale.** The latched value sets the bit period in cycles. Values 0 and 1 are clamped to 2. The legal range is therefore 2..31.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on accept.
  - START → DATA after one bit period.
  - DATA → PARITY after DATA_WIDTH bit periods, if parity is enabled for this frame; otherwise DATA → STOP.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after one bit period.
- **Line levels.** START drives 0. DATA drives the latched byte LSB first, using a right-shift register. STOP and IDLE drive 1.
- **Parity bit.** Even parity = XOR of the data bits. Odd parity = the inverse of that.
- **Counters.** The bit-period counter runs 0..prescale−1 and wraps; the wrap advances the bit or state. The data bit index is 3 bits wide (clog2 of DATA_WIDTH) and wraps at DATA_WIDTH−1.
- **Reset.** `rst` in any state, including mid-frame, forces IDLE on the next edge. The frame in flight is abandoned and no partial stop bit is emitted.

## Timing
- **Reset values:** `TX_OUT`=1, `busy`=0, state IDLE, counters 0, shift register 0.
- **Start latency.** Accept at edge N. From the cycle after edge N, `TX_OUT`=0 and `busy`=1; both outputs are registered.
- **Frame length** = (1 + DATA_WIDTH + P + 1) × prescale cycles, where P = 1 if parity is sent, else 0. With prescale=8 and no parity this is 80 cycles.
- **End of frame.** `busy` falls on the edge that ends the last stop-bit cycle. The earliest next accept is that same low cycle.
- **Back-to-back frames** therefore have a stop level lasting prescale+1 cycles. That is one idle cycle between frames, which is legal for any UART receiver.
- **No glitches.** `TX_OUT` changes only on bit-period boundaries.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state, the parity calculation, and the `PAR_EN`/`PAR_TYP` latches are built.
- **Undefined:**
  - The PARITY state and its logic are absent.
  - `PAR_EN` and `PAR_TYP` remain as ports but are unused.
  - Every frame is 1+DATA_WIDTH+1 bits.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum `uart_tx_state_t`.
  - Constants `PAR_EVEN`=0 and `PAR_ODD`=1.
  - `PRESCALE_MIN`=2.
  - Frame bit-count constants.
  - These are also used by the RX side.
- **Sub-module `uart_parity_calc`:** combinational XOR reduction of the data plus the type select. The RX parity checker reuses it. It is instantiated only under `UART_TX_PARITY_EN`.
- **Main module:** FSM, bit-period counter, bit index and shift register stay in `uart_tx`.

## Test plan
1. **Basic frame, no parity.** Reset, then `P_DATA`=0xC5, prescale=8, `PAR_EN`=0, `DATA_VALID` pulsed for one cycle. `TX_OUT` must be 0,1,0,1,0,0,0,1,1,1, each bit held 8 cycles. `busy` must be high for exactly 80 cycles.
2. **Parity** (macro defined). 0xC5 with `PAR_EN`=1:
   - `PAR_TYP`=0 → parity bit 0.
   - `PAR_TYP`=1 → parity bit 1.
   - Frame must be 88 cycles at prescale=8.
3. **Drop while busy.** Hold `DATA_VALID` high with `P_DATA` changing to 0x3A mid-frame. The first frame must be unchanged. A second frame carrying 0x3A must start in the first cycle `busy` is low.
4. **Reset mid-frame.** Assert `rst` during data bit 3. The next cycle must show `TX_OUT`=1, `busy`=0 and state IDLE. A new 0xFF frame must then send correctly.
5. **Prescale clamp and max.** prescale=0 → 2-cycle bits. prescale=31 → 31-cycle bits. Changing `prescale` mid-frame must not alter the current frame.
6. **Loopback.** Connect to the UART_RX receiver with matching prescale and 256 random bytes. Every byte must be received intact. With parity enabled, no parity errors may be reported.
